// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared types and helpers for the LED scan controller.
//   scan_state_t : scan FSM states
//   col_w(n)     : width of the column index output for an n-column grid
package led_scan_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t;

    function automatic int col_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/led_scan_if.sv
// led_scan_if: valid/ready frame hand-over from the generation logic to the scan controller.
//   frame_valid : upstream presents a new grid
//   frame_data  : grid, bit r*N+c = cell (row r, col c)
//   frame_ready : controller can take a grid this cycle
interface led_scan_if #(parameter int N = 5);

    logic           frame_valid;
    logic [N*N-1:0] frame_data;
    logic           frame_ready;

    modport master (output frame_valid, frame_data, input frame_ready);
    modport slave  (input frame_valid, frame_data, output frame_ready);

endinterface

// File: rtl/scan_timer.sv
// scan_timer: column-slot counter running 0..PRESCALE-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, holds the count at 0
//   cnt_nxt    : value the counter takes on the next edge
//   tick       : terminal count (last cycle of a slot)
module scan_timer #(
    parameter int PRESCALE = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    output logic [$clog2(PRESCALE)-1:0] cnt_nxt,
    output logic                        tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;

    assign tick    = !clr && cnt == CW'(PRESCALE - 1);
    assign cnt_nxt = (clr || tick) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;

endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column scan sequencer with double-buffered cell frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : scan enable; low blanks and restarts the scan
//   frame      : slave side of the grid hand-over (valid/data/ready)
//   ena        : driver enable, low during the blanking part of each slot
//   x          : current column index
//   cells      : displayed grid
//   frame_done : one-cycle pulse after each frame boundary
module led_scan_controller
    import led_scan_pkg::*;
#(
    parameter int N        = 5,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    led_scan_if.slave            frame,
    output logic                 ena,
    output logic [col_w(N)-1:0]  x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_done
);

    localparam int COL_W = col_w(N);
    localparam int CW    = $clog2(PRESCALE);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_scan_controller: N must be 1..8");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("led_scan_controller: PRESCALE must be >= 2");
    end
    if (BLANK < 0 || BLANK >= PRESCALE) begin : g_bad_blank
        $error("led_scan_controller: BLANK must be 0..PRESCALE-1");
    end

    scan_state_t    state, state_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic           tick, boundary, accept, pending_full;
    logic [COL_W-1:0] col;
    logic [N*N-1:0] pending;

    scan_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!run),
        .cnt_nxt (cnt_nxt),
        .tick    (tick)
    );

    assign boundary          = tick && col == COL_W'(N - 1);
    assign accept            = frame.frame_valid && !pending_full;
    assign frame.frame_ready = !pending_full;
    assign ena               = state == S_DRIVE;
    assign x                 = col;

    // State tracks the slot position the counter is about to enter, so the
    // blank/drive split lines up exactly with the new count.
    assign state_nxt = !run ? S_IDLE : (int'(cnt_nxt) < BLANK ? S_BLANK : S_DRIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            col          <= '0;
            cells        <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= boundary;
            if (!run)      col <= '0;
            else if (tick) col <= boundary ? '0 : col + 1'b1;
            // Accept needs an empty pending buffer, so it never coincides
            // with a swap; a grid taken on a boundary waits a full frame.
            if (boundary && pending_full) begin
                cells        <= pending;
                pending_full <= 1'b0;
            end else if (accept) begin
                pending      <= frame.frame_data;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: scoreboard bench; stimulus queues the grid expected
// at each frame_done pulse, a negedge monitor pops and compares.
module tb_led_scan_controller;

    localparam int N = 5;
    localparam int P = 10;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        ena, frame_done;
    logic [3:0]  x;
    logic [24:0] cells;

    led_scan_if #(.N(N)) fif();

    led_scan_controller #(.N(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .frame      (fif),
        .ena        (ena),
        .x          (x),
        .cells      (cells),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int k = 0;
    logic [24:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic upto(input int t);
        while (k < t) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ena"}, {31'd0, ena}, 0);
        chk({tag, "_x"}, {28'd0, x}, 0);
        chk({tag, "_cells"}, {7'd0, cells}, 0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        chk({tag, "_ready"}, {31'd0, fif.frame_ready}, 1);
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_done_unexpected k=%0d: got pulse expected none", k);
            end else begin
                chk("frame_cells", {7'd0, cells}, {7'd0, exp_q.pop_front()});
                chk("frame_x", {28'd0, x}, 0);
            end
        end
    end

    initial begin
        fif.frame_valid = 1'b0;
        fif.frame_data  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        step();
        chk("idle_ena", {31'd0, ena}, 0);

        // Free-running scan: x 0..4, 2 blank + 8 drive cycles per column.
        run = 1'b1;
        k = 0;
        exp_q.push_back(25'h0);
        for (int i = 0; i < 55; i++) begin
            chk("scan_x", {28'd0, x}, (k / 10) % 5);
            chk("scan_ena", {31'd0, ena}, (k % 10) >= 2 ? 1 : 0);
            step();
        end

        // Mid-frame accept; display waits for the boundary at k=100.
        chk("ready_before_accept", {31'd0, fif.frame_ready}, 1);
        fif.frame_valid = 1'b1;
        fif.frame_data  = 25'h1555555;
        exp_q.push_back(25'h1555555);
        step();
        fif.frame_valid = 1'b0;
        chk("ready_after_accept", {31'd0, fif.frame_ready}, 0);
        chk("cells_before_swap", {7'd0, cells}, 0);

        // Held valid while pending is full; taken right after the swap.
        upto(60);
        fif.frame_valid = 1'b1;
        fif.frame_data  = 25'h0AAAAAA;
        exp_q.push_back(25'h0AAAAAA);
        upto(99);
        chk("ready_full_hold", {31'd0, fif.frame_ready}, 0);
        chk("cells_last_cycle", {7'd0, cells}, 0);
        step();
        chk("ready_at_swap", {31'd0, fif.frame_ready}, 1);
        chk("cells_at_swap", {7'd0, cells}, 25'h1555555);
        step();
        fif.frame_valid = 1'b0;
        chk("ready_held_taken", {31'd0, fif.frame_ready}, 0);
        chk("cells_after_swap", {7'd0, cells}, 25'h1555555);
        upto(150);
        chk("cells_second_swap", {7'd0, cells}, 25'h0AAAAAA);
        chk("ready_second_swap", {31'd0, fif.frame_ready}, 1);

        // Accept on the boundary cycle with pending empty: no bypass.
        upto(199);
        exp_q.push_back(25'h0AAAAAA);
        exp_q.push_back(25'h00F0F0F);
        fif.frame_valid = 1'b1;
        fif.frame_data  = 25'h00F0F0F;
        step();
        fif.frame_valid = 1'b0;
        chk("boundary_accept_cells", {7'd0, cells}, 25'h0AAAAAA);
        chk("boundary_accept_ready", {31'd0, fif.frame_ready}, 0);
        upto(249);
        chk("boundary_accept_wait", {7'd0, cells}, 25'h0AAAAAA);
        step();
        chk("boundary_accept_shown", {7'd0, cells}, 25'h00F0F0F);

        // Drop run at col 3, cnt 6.
        upto(286);
        chk("pre_drop_x", {28'd0, x}, 3);
        chk("pre_drop_ena", {31'd0, ena}, 1);
        run = 1'b0;
        step();
        chk("drop_ena", {31'd0, ena}, 0);
        chk("drop_x", {28'd0, x}, 0);
        upto(292);
        chk("idle_hold_ena", {31'd0, ena}, 0);
        chk("idle_hold_cells", {7'd0, cells}, 25'h00F0F0F);

        // Restart: col 0 with two blank cycles.
        run = 1'b1;
        k = 0;
        exp_q.push_back(25'h00F0F0F);
        for (int i = 0; i < 13; i++) begin
            chk("restart_x", {28'd0, x}, (k / 10) % 5);
            chk("restart_ena", {31'd0, ena}, (k % 10) >= 2 ? 1 : 0);
            step();
        end

        // Reset mid-frame with pending full: pending is discarded.
        upto(60);
        fif.frame_valid = 1'b1;
        fif.frame_data  = 25'h1FFFFFF;
        step();
        fif.frame_valid = 1'b0;
        chk("pending_full_before_reset", {31'd0, fif.frame_ready}, 0);
        upto(72);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        exp_q.push_back(25'h0);
        upto(12);
        chk("post_reset_x", {28'd0, x}, 1);
        upto(51);
        chk("post_reset_cells", {7'd0, cells}, 0);
        upto(55);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
